// File: rtl/wt_dcache_reuse_pred.sv
// Signature-based reuse predictor for the write-through dcache: learns per-signature
// dead-on-arrival behaviour and suggests an LRU insertion depth for each issued miss.
module wt_dcache_reuse_pred #(
    parameter int unsigned NUM_SETS  = 256,
    parameter int unsigned NUM_WAYS  = 4,
    parameter int unsigned SIG_WIDTH = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        flush_i,
    input  logic                        miss_req_i,
    input  logic [SIG_WIDTH-1:0]        miss_sig_i,
    output logic                        ready_o,
    output logic                        pred_valid_o,
    output logic [1:0]                  pred_result_o,
    input  logic                        fill_i,
    input  logic [$clog2(NUM_SETS)-1:0] fill_idx_i,
    input  logic [1:0]                  fill_way_i,
    input  logic                        hit_i,
    input  logic [$clog2(NUM_SETS)-1:0] hit_idx_i,
    input  logic [1:0]                  hit_way_i
);

    localparam int unsigned IDX_W      = $clog2(NUM_SETS);
    localparam int unsigned ENT_W      = IDX_W + 2;
    localparam int unsigned ENTRIES    = NUM_SETS * NUM_WAYS;
    localparam int unsigned SHCT_DEPTH = 2 ** SIG_WIDTH;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [SIG_WIDTH-1:0] sig_q;
    logic [1:0]           pred_q;

    logic [1:0]           shct_q [SHCT_DEPTH];
    logic [ENTRIES-1:0]   valid_q;
    logic [ENTRIES-1:0]   reused_q;
    logic [SIG_WIDTH-1:0] sig_mem_q [ENTRIES];

    logic [ENT_W-1:0]     fill_ent, hit_ent;
    logic [SIG_WIDTH-1:0] train_sig, dec_sig;
    logic                 pending_q, accept, train, dec, cancel, inc_en, dec_en;

    assign pending_q = (state_q == ST_PEND);
    assign fill_ent  = {fill_idx_i, fill_way_i};
    assign hit_ent   = {hit_idx_i, hit_way_i};
    assign train_sig = sig_mem_q[fill_ent];
    assign dec_sig   = sig_mem_q[hit_ent];

    // Flush wins over every other same-cycle event
    assign accept = miss_req_i && !pending_q && !flush_i;
    assign train  = fill_i && !flush_i && valid_q[fill_ent] && !reused_q[fill_ent];
    assign dec    = hit_i && !flush_i && valid_q[hit_ent] && !reused_q[hit_ent];
    // Opposing updates to one counter cancel even when one of them would saturate
    assign cancel = train && dec && (train_sig == dec_sig);
    assign inc_en = train && !cancel;
    assign dec_en = dec && !cancel;

    // Miss tracking: idle until a miss is accepted, pending until its fill returns
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (miss_req_i) state_d = ST_PEND;
                ST_PEND: if (fill_i)     state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latched miss signature and its pre-update counter value
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sig_q  <= '0;
            pred_q <= 2'd0;
        end else if (accept) begin
            sig_q  <= miss_sig_i;
            pred_q <= shct_q[miss_sig_i];
        end
    end

    // Saturating counters; increment and decrement never share an index here
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < SHCT_DEPTH; i++) begin
                shct_q[i] <= 2'd1;
            end
        end else begin
            if (inc_en && (shct_q[train_sig] != 2'd3)) begin
                shct_q[train_sig] <= shct_q[train_sig] + 2'd1;
            end
            if (dec_en && (shct_q[dec_sig] != 2'd0)) begin
                shct_q[dec_sig] <= shct_q[dec_sig] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (fill_i) begin
            valid_q[fill_ent] <= pending_q;
        end
    end

    // Signature and reuse bits are qualified by valid_q, so they need no reset
    always_ff @(posedge clk_i) begin
        if (!flush_i) begin
            if (dec) begin
                reused_q[hit_ent] <= 1'b1;
            end
            if (fill_i) begin
                sig_mem_q[fill_ent] <= sig_q;
                reused_q[fill_ent]  <= 1'b0;
            end
        end
    end

    assign ready_o       = !pending_q;
    assign pred_valid_o  = pending_q;
    assign pred_result_o = pending_q ? pred_q : 2'd1;

endmodule
